// File: rtl/instr_loader_pkg.sv
// Shared instruction-format definitions for the loader (encoder) and the control decoder.
package instr_loader_pkg;

  localparam int IW     = 9;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int OPND_W = 6;

  localparam logic [2:0] LSW_SUB_LW = 3'b001;
  localparam logic [2:0] LSW_SUB_SW = 3'b000;

  typedef enum logic [2:0] {
    kLSW    = 3'd0,
    kERRFLG = 3'd1,
    kSET    = 3'd2,
    kBNE    = 3'd3,
    kPAR    = 3'd4,
    kADD    = 3'd5,
    kXOR    = 3'd6,
    kLSOR   = 3'd7
  } op_mne_e;

  // Load/store keeps only the upper operand half; the low three bits carry the LW/SW sub-code.
  function automatic logic [IW-1:0] encode_instr(input op_mne_e op, input logic is_load,
                                                 input logic [OPND_W-1:0] operand);
    logic [IW-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB] = op;
    if (op == kLSW) w[OPND_W-1:0] = {operand[5:3], is_load ? LSW_SUB_LW : LSW_SUB_SW};
    else            w[OPND_W-1:0] = operand;
    return w;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Symbolic-instruction valid/ready stream feeding the loader.
interface instr_loader_if;
  import instr_loader_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  op_mne_e               in_op;
  logic                  in_is_load;
  logic [OPND_W-1:0]     in_operand;
  logic                  in_last;

  modport master (output in_valid, in_op, in_is_load, in_operand, in_last, input in_ready);
  modport slave  (input in_valid, in_op, in_is_load, in_operand, in_last, output in_ready);
endinterface

// File: rtl/instr_loader_fifo.sv
// Small synchronous first-word-fall-through FIFO holding encoded words awaiting their memory write.
module instr_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // A push into a full FIFO is legal when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rdata = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Encodes symbolic instructions and writes them sequentially into instruction memory.
// Optional INSTR_LOADER_CHECKSUM_EN adds an XOR checksum of the words written this session.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  instr_loader_if.slave in_if,
  output logic          imem_wr_en,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] imem_wr_data,
  output logic          busy,
  output logic          done,
  output logic          overflow
`ifdef INSTR_LOADER_CHECKSUM_EN
  ,output logic [IW-1:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  localparam logic [AW-1:0] ADDR_ONE = 1;

  state_e        state;
  logic [IW-1:0] enc_word, fifo_rdata;
  logic          fifo_full, fifo_empty, push, pop, start_session;
  logic [AW-1:0] wr_addr;
  logic          addr_end;

  assign enc_word      = encode_instr(in_if.in_op, in_if.in_is_load, in_if.in_operand);
  assign pop           = !fifo_empty;
  assign in_if.in_ready = (state == LOAD) && (!fifo_full || pop);
  assign push          = in_if.in_valid && in_if.in_ready;
  assign start_session = start && (state == IDLE || state == DONE);

  instr_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (enc_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // DRAIN waits for the FIFO to empty, so DONE lands the cycle after the final strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
        LOAD: if (push && in_if.in_last) state <= DRAIN;
        DRAIN: if (fifo_empty) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Once the top address has been written, any further word is dropped and flags overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_wr_en   <= 1'b0;
      imem_addr    <= '0;
      imem_wr_data <= '0;
      wr_addr      <= '0;
      addr_end     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      imem_wr_en <= 1'b0;
      if (start_session) begin
        wr_addr  <= '0;
        addr_end <= 1'b0;
        overflow <= 1'b0;
      end else if (pop) begin
        if (addr_end) begin
          overflow <= 1'b1;
        end else begin
          imem_wr_en   <= 1'b1;
          imem_addr    <= wr_addr;
          imem_wr_data <= fifo_rdata;
          wr_addr      <= wr_addr + ADDR_ONE;
          if (&wr_addr) addr_end <= 1'b1;
        end
      end
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      checksum <= '0;
    else if (start_session)          checksum <= '0;
    else if (pop && !addr_end)       checksum <= checksum ^ fifo_rdata;
  end
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Randomised self-checking bench for instr_loader against a word-list reference model.
module tb_instr_loader;
  import instr_loader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_b = 1'b0, start_s = 1'b0;
  logic valid = 1'b0, isl = 1'b0, last = 1'b0;
  logic [2:0] opv = '0;
  logic [5:0] opd = '0;
  bit   sel = 1'b0;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  int b_op [32];
  bit b_isl [32];
  int b_opd [32];

  logic [9:0] got_addr [$];
  logic [8:0] got_data [$];

  logic       wr_b, busy_b, done_b, ovf_b;
  logic [9:0] addr_b;
  logic [8:0] data_b;
  logic       wr_s, busy_s, done_s, ovf_s;
  logic [1:0] addr_s;
  logic [8:0] data_s;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [8:0] ck_b, ck_s;
`endif

  always #5 clk = ~clk;

  instr_loader_if ifb ();
  instr_loader_if ifs ();

  assign ifb.in_valid   = valid;
  assign ifb.in_op      = op_mne_e'(opv);
  assign ifb.in_is_load = isl;
  assign ifb.in_operand = opd;
  assign ifb.in_last    = last;
  assign ifs.in_valid   = valid;
  assign ifs.in_op      = op_mne_e'(opv);
  assign ifs.in_is_load = isl;
  assign ifs.in_operand = opd;
  assign ifs.in_last    = last;

  instr_loader #(.AW(10), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_if(ifb),
    .imem_wr_en(wr_b), .imem_addr(addr_b), .imem_wr_data(data_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b)
`ifdef INSTR_LOADER_CHECKSUM_EN
    , .checksum(ck_b)
`endif
  );

  instr_loader #(.AW(2), .DEPTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_if(ifs),
    .imem_wr_en(wr_s), .imem_addr(addr_s), .imem_wr_data(data_s),
    .busy(busy_s), .done(done_s), .overflow(ovf_s)
`ifdef INSTR_LOADER_CHECKSUM_EN
    , .checksum(ck_s)
`endif
  );

  always @(negedge clk) begin
    if (sel ? wr_s : wr_b) begin
      got_addr.push_back(sel ? {8'b0, addr_s} : addr_b);
      got_data.push_back(sel ? data_s : data_b);
    end
  end

  function automatic logic [8:0] model_word(input int op, input bit il, input int operand);
    int w;
    if (op == 0) w = (operand / 8) * 8 + (il ? 1 : 0);
    else         w = op * 64 + operand;
    return w[8:0];
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      b_op[i]  = $urandom_range(0, 7);
      b_isl[i] = 1'($urandom_range(0, 1));
      b_opd[i] = $urandom_range(0, 63);
    end
  endtask

  task automatic start_session();
    if (sel) start_s = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic drive_beat(input int i, input int n, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    valid = 1'b1;
    opv   = b_op[i][2:0];
    isl   = b_isl[i];
    opd   = b_opd[i][5:0];
    last  = (i == n - 1);
    t = 0;
    while (!(sel ? ifs.in_ready : ifb.in_ready) && t < 50) begin
      stalls++;
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) begin
      errors++;
      $display("[TB] FAIL accept_timeout beat %0d: in_ready=0 after 50 cycles, required 1", i);
    end
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!(sel ? done_s : done_b) && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("[TB] FAIL done_timeout: done=0 after 200 cycles, required 1");
    end
  endtask

  task automatic run_session(input int n, input bit gaps);
    int cap, exp_n;
    logic [8:0] e, ck;
    got_addr.delete();
    got_data.delete();
    start_session();
    for (int i = 0; i < n; i++) drive_beat(i, n, gaps);
    wait_done();
    repeat (2) @(negedge clk);
    cap   = sel ? 4 : 1024;
    exp_n = (n < cap) ? n : cap;
    ck    = '0;
    checks++;
    if (got_addr.size() != exp_n) begin
      errors++;
      $display("[TB] FAIL write_count: got %0d, required %0d", got_addr.size(), exp_n);
    end
    for (int i = 0; i < exp_n && i < got_addr.size(); i++) begin
      e = model_word(b_op[i], b_isl[i], b_opd[i]);
      ck = ck ^ e;
      checks++;
      if (got_addr[i] !== 10'(i) || got_data[i] !== e) begin
        errors++;
        $display("[TB] FAIL write[%0d]: got addr %0d data %h, required addr %0d data %h",
                 i, got_addr[i], got_data[i], i, e);
      end
    end
    checks++;
    if ((sel ? ovf_s : ovf_b) !== (n > cap)) begin
      errors++;
      $display("[TB] FAIL overflow: got %b, required %b", sel ? ovf_s : ovf_b, n > cap);
    end
    checks++;
    if ((sel ? busy_s : busy_b) !== 1'b0 || (sel ? done_s : done_b) !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_state: got busy %b done %b, required busy 0 done 1",
               sel ? busy_s : busy_b, sel ? done_s : done_b);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    checks++;
    if ((sel ? ck_s : ck_b) !== ck) begin
      errors++;
      $display("[TB] FAIL checksum: got %h, required %h", sel ? ck_s : ck_b, ck);
    end
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (wr_b !== 1'b0 || addr_b !== '0 || data_b !== '0 || busy_b !== 1'b0 ||
        done_b !== 1'b0 || ovf_b !== 1'b0 || ifb.in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s: got wr %b addr %0d data %h busy %b done %b ovf %b rdy %b, required all 0",
               tag, wr_b, addr_b, data_b, busy_b, done_b, ovf_b, ifb.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_single();
    sel = 1'b0;
    start_session();
    valid = 1'b1; opv = 3'd5; isl = 1'b1; opd = 6'h15; last = 1'b1;
    checks++;
    if (ifb.in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_ready: got %b, required 1", ifb.in_ready);
    end
    @(negedge clk);
    valid = 1'b0; last = 1'b0;
    checks++;
    if (wr_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early_strobe: got %b, required 0", wr_b);
    end
    @(negedge clk);
    checks++;
    if (wr_b !== 1'b1 || addr_b !== 10'd0 || data_b !== 9'h155 || done_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_write: got wr %b addr %0d data %h done %b, required 1 0 155 0",
               wr_b, addr_b, data_b, done_b);
    end
    @(negedge clk);
    checks++;
    if (done_b !== 1'b1 || busy_b !== 1'b0 || wr_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done: got done %b busy %b wr %b, required 1 0 0", done_b, busy_b, wr_b);
    end
  endtask

  task automatic test_lsw();
    logic [8:0] req [2];
    req[0] = 9'h039;
    req[1] = 9'h038;
    sel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b_op[0] = 0; b_isl[0] = (k == 0); b_opd[0] = 63;
      run_session(1, 1'b0);
      checks++;
      if (got_data.size() == 0 || got_data[0] !== req[k]) begin
        errors++;
        $display("[TB] FAIL lsw_encode[%0d]: got %h, required %h", k,
                 (got_data.size() == 0) ? 9'h1ff : got_data[0], req[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    fill_random(8);
    stalls = 0;
    run_session(8, 1'b0);
    checks++;
    if (stalls != 0) begin
      errors++;
      $display("[TB] FAIL b2b_ready: got %0d stall cycles, required 0", stalls);
    end
  endtask

  task automatic test_overflow();
    sel = 1'b1;
    fill_random(5);
    run_session(5, 1'b1);
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    fill_random(5);
    start_session();
    drive_beat(0, 5, 1'b0);
    drive_beat(1, 5, 1'b0);
    #1 rst_n = 1'b0;
    got_addr.delete();
    got_data.delete();
    #1 check_idle_outputs("mid_reset_outputs");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("after_mid_reset");
    checks++;
    if (got_addr.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_writes: got %0d strobes, required 0", got_addr.size());
    end
    fill_random(3);
    run_session(3, 1'b1);
  endtask

  task automatic test_random();
    sel = 1'b0;
    for (int s = 0; s < 4; s++) begin
      int n;
      n = $urandom_range(1, 12);
      fill_random(n);
      run_session(n, 1'b1);
    end
  endtask

`ifdef INSTR_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    sel = 1'b0;
    b_op[0] = 5; b_isl[0] = 1'b0; b_opd[0] = 'h15;
    b_op[1] = 0; b_isl[1] = 1'b1; b_opd[1] = 'h3F;
    run_session(2, 1'b0);
    checks++;
    if (ck_b !== 9'h16C) begin
      errors++;
      $display("[TB] FAIL checksum_const: got %h, required 16c", ck_b);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_lsw();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random();
`ifdef INSTR_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
